// File: rtl/tt_slot_driver.sv
// tt_slot_driver
//   Chip-side driver for the per-project iw/ow wrapper buses. It broadcasts
//   {uio_in, ui_in, proj_rst_n, proj_clk} to every slot, enables exactly one
//   slot (or none), and returns the selected slot's {uio_oe, uio_out, uo_out}
//   to the pads. A slot change always runs stop-clock, disable, reset, run.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sel_valid/addr    slot select request (addr >= N_SLOTS means "all off")
//   sel_ready         request accepted when sel_valid && sel_ready (OFF/RUN)
//   busy              switch sequence in progress (STOP/GAP/RESET)
//   cur_sel           slot latched in GAP
//   ui_pad/uio_pad_in pad inputs, registered onto iw
//   ext_rst_n         user project reset pad, synchronised into proj_rst_n
//   iw                broadcast {uio_in, ui_in, proj_rst_n, proj_clk}
//   ena               one-hot or all-zero slot enable
//   ow_all            concatenated ow words, slot k at [24k+23:24k]
//   uo_pad/uio_pad_*  registered ow fields of the selected slot
module tt_slot_driver #(
    parameter int unsigned N_SLOTS  = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned RST_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_valid,
    input  logic [ADDR_W-1:0]     sel_addr,
    output logic                  sel_ready,
    output logic                  busy,
    output logic [ADDR_W-1:0]     cur_sel,
    input  logic [7:0]            ui_pad,
    input  logic [7:0]            uio_pad_in,
    input  logic                  ext_rst_n,
    output logic [17:0]           iw,
    output logic [N_SLOTS-1:0]    ena,
    input  logic [N_SLOTS*24-1:0] ow_all,
    output logic [7:0]            uo_pad,
    output logic [7:0]            uio_pad_out,
    output logic [7:0]            uio_pad_oe
);

    localparam int unsigned DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]  DIV_PRE  = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);

    typedef enum logic [2:0] {S_OFF, S_STOP, S_GAP, S_RESET, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d, div_inc;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   req_q, req_d;
    logic [ADDR_W-1:0]   cur_sel_q, cur_sel_d;
    logic                sync1_q;
    logic                pclk_q, pclk_d;
    logic                prst_q, prst_d;
    logic [7:0]          ui_q, ui_d, uio_in_q, uio_in_d;
    logic [N_SLOTS-1:0]  ena_q, ena_d;
    logic [23:0]         slot_ow, pads_q, pads_d;
    logic                busy_q, busy_d, ready_q, ready_d;
    logic                accept, live_d, powered_d;

    assign accept  = sel_valid && ready_q;
    assign div_inc = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        hold_d    = hold_q;
        req_d     = req_q;
        cur_sel_d = cur_sel_q;
        case (state_q)
            S_OFF: begin
                div_d = '0;
                if (accept) begin
                    state_d = S_GAP;
                    req_d   = sel_addr;
                end
            end
            S_RUN: begin
                div_d = div_inc;
                if (accept) begin
                    state_d = S_STOP;
                    req_d   = sel_addr;
                end
            end
            // Finish the current proj_clk period so the slot never sees a runt pulse.
            S_STOP: begin
                div_d = div_inc;
                if (div_q == DIV_LAST) state_d = S_GAP;
            end
            S_GAP: begin
                div_d     = '0;
                hold_d    = '0;
                cur_sel_d = req_q;
                state_d   = (32'(req_q) >= N_SLOTS) ? S_OFF : S_RESET;
            end
            // A proj_clk rising edge happens on the DIV_PRE -> DIV_HALF step;
            // leave at the period boundary after the RST_HOLD-th one.
            S_RESET: begin
                div_d = div_inc;
                if (div_q == DIV_PRE && hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
                if (div_q == DIV_LAST && hold_q == HOLD_MAX) state_d = S_RUN;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Registered outputs are computed from next-state values so they line up with state_q.
    always_comb begin
        live_d    = (state_d == S_RESET) || (state_d == S_RUN);
        powered_d = live_d || (state_d == S_STOP);
        busy_d    = (state_d == S_STOP) || (state_d == S_GAP) || (state_d == S_RESET);
        ready_d   = (state_d == S_OFF) || (state_d == S_RUN);
        pclk_d    = powered_d && (div_d >= DIV_HALF);
        // sync1_q -> prst_q forms the two-flop synchroniser for ext_rst_n.
        prst_d    = (state_d == S_RUN) && sync1_q;
        ui_d      = live_d ? ui_pad : '0;
        uio_in_d  = live_d ? uio_pad_in : '0;
        slot_ow   = '0;
        ena_d     = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (cur_sel_d == ADDR_W'(i)) begin
                slot_ow  = ow_all[i*24 +: 24];
                ena_d[i] = powered_d;
            end
        end
        pads_d = live_d ? slot_ow : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            div_q     <= '0;
            hold_q    <= '0;
            req_q     <= '0;
            cur_sel_q <= '0;
            sync1_q   <= 1'b0;
            pclk_q    <= 1'b0;
            prst_q    <= 1'b0;
            ui_q      <= '0;
            uio_in_q  <= '0;
            ena_q     <= '0;
            pads_q    <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            req_q     <= req_d;
            cur_sel_q <= cur_sel_d;
            sync1_q   <= ext_rst_n;
            pclk_q    <= pclk_d;
            prst_q    <= prst_d;
            ui_q      <= ui_d;
            uio_in_q  <= uio_in_d;
            ena_q     <= ena_d;
            pads_q    <= pads_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign iw          = {uio_in_q, ui_q, prst_q, pclk_q};
    assign ena         = ena_q;
    assign uo_pad      = pads_q[7:0];
    assign uio_pad_out = pads_q[15:8];
    assign uio_pad_oe  = pads_q[23:16];
    assign busy        = busy_q;
    assign sel_ready   = ready_q;
    assign cur_sel     = cur_sel_q;

endmodule

// File: tb/tb_tt_slot_driver.sv
// Two instances (CLK_DIV=2 and CLK_DIV=4) share the pad/ow inputs and each has
// its own select strobe. The reference model tracks the slot-switch sequence in
// terms of elapsed cycles: proj_clk phase is (cycles since RESET entry) mod
// CLK_DIV, and RESET lasts exactly RST_HOLD*CLK_DIV cycles.
module tb_tt_slot_driver;

    localparam int unsigned NS = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned RH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           sv = 2'b00;
    logic [AW-1:0]        sel_addr = '0;
    logic [7:0]           ui_pad = '0;
    logic [7:0]           uio_pad_in = '0;
    logic                 ext_rst_n = 1'b1;
    logic [NS*24-1:0]     ow_all = '0;

    logic                 rdy_w [2];
    logic                 busy_w [2];
    logic [AW-1:0]        cs_w [2];
    logic [17:0]          iw_w [2];
    logic [NS-1:0]        ena_w [2];
    logic [7:0]           uo_w [2];
    logic [7:0]           uioo_w [2];
    logic [7:0]           oe_w [2];

    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    tt_slot_driver #(.N_SLOTS(NS), .ADDR_W(AW), .CLK_DIV(2), .RST_HOLD(RH)) u_d2 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sv[0]), .sel_addr(sel_addr),
        .sel_ready(rdy_w[0]), .busy(busy_w[0]), .cur_sel(cs_w[0]),
        .ui_pad(ui_pad), .uio_pad_in(uio_pad_in), .ext_rst_n(ext_rst_n),
        .iw(iw_w[0]), .ena(ena_w[0]), .ow_all(ow_all),
        .uo_pad(uo_w[0]), .uio_pad_out(uioo_w[0]), .uio_pad_oe(oe_w[0])
    );

    tt_slot_driver #(.N_SLOTS(NS), .ADDR_W(AW), .CLK_DIV(4), .RST_HOLD(RH)) u_d4 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sv[1]), .sel_addr(sel_addr),
        .sel_ready(rdy_w[1]), .busy(busy_w[1]), .cur_sel(cs_w[1]),
        .ui_pad(ui_pad), .uio_pad_in(uio_pad_in), .ext_rst_n(ext_rst_n),
        .iw(iw_w[1]), .ena(ena_w[1]), .ow_all(ow_all),
        .uo_pad(uo_w[1]), .uio_pad_out(uioo_w[1]), .uio_pad_oe(oe_w[1])
    );

    // ---------------- reference model ----------------
    typedef enum {M_OFF, M_STOP, M_GAP, M_RESET, M_RUN} mst_t;
    mst_t        m_st [2];
    int unsigned m_sel [2];
    int unsigned m_req [2];
    int unsigned m_t0 [2];
    logic        m_acc [2];
    int unsigned cyc = 0;
    logic        ext_prev = 1'b0;

    logic [NS-1:0] e_ena [2];
    logic [17:0]   e_iw [2];
    logic [23:0]   e_pads [2];
    logic          e_busy [2];
    logic          e_rdy [2];

    function automatic int unsigned cdv(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_OFF; m_sel[k] = 0; m_req[k] = 0; m_t0[k] = cyc; m_acc[k] = 1'b0;
            e_ena[k] = '0; e_iw[k] = '0; e_pads[k] = '0; e_busy[k] = 1'b0; e_rdy[k] = 1'b1;
        end
        ext_prev = 1'b0;
    endtask

    task automatic model_edge();
        int unsigned cd, d;
        logic live, pow, pclk, prst;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            cd = cdv(k);
            d = (cyc - 1 - m_t0[k]) % cd;
            m_acc[k] = 1'b0;
            case (m_st[k])
                M_OFF, M_RUN: if (sv[k]) begin
                    m_st[k] = (m_st[k] == M_OFF) ? M_GAP : M_STOP;
                    m_req[k] = int'(sel_addr);
                    m_acc[k] = 1'b1;
                end
                M_STOP: if (d == cd - 1) m_st[k] = M_GAP;
                M_GAP: begin
                    m_sel[k] = m_req[k];
                    if (m_req[k] >= NS) m_st[k] = M_OFF;
                    else begin
                        m_st[k] = M_RESET;
                        m_t0[k] = cyc;
                    end
                end
                M_RESET: if (cyc - m_t0[k] == RH * cd) m_st[k] = M_RUN;
                default: m_st[k] = M_OFF;
            endcase
            live = (m_st[k] == M_RESET) || (m_st[k] == M_RUN);
            pow  = live || (m_st[k] == M_STOP);
            pclk = pow && (((cyc - m_t0[k]) % cd) >= cd / 2);
            prst = (m_st[k] == M_RUN) && ext_prev;
            e_ena[k]  = pow ? (NS'(1) << m_sel[k]) : '0;
            e_iw[k]   = live ? {uio_pad_in, ui_pad, prst, pclk} : {16'h0, prst, pclk};
            e_pads[k] = live ? ow_all[m_sel[k]*24 +: 24] : '0;
            e_busy[k] = (m_st[k] == M_STOP) || (m_st[k] == M_GAP) || (m_st[k] == M_RESET);
            e_rdy[k]  = (m_st[k] == M_OFF) || (m_st[k] == M_RUN);
        end
        ext_prev = ext_rst_n;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("ena", k, ena_w[k], e_ena[k]);
            chk("iw", k, 32'(iw_w[k]), 32'(e_iw[k]));
            chk("uo_pad", k, 32'(uo_w[k]), 32'(e_pads[k][7:0]));
            chk("uio_pad_out", k, 32'(uioo_w[k]), 32'(e_pads[k][15:8]));
            chk("uio_pad_oe", k, 32'(oe_w[k]), 32'(e_pads[k][23:16]));
            chk("busy", k, 32'(busy_w[k]), 32'(e_busy[k]));
            chk("sel_ready", k, 32'(rdy_w[k]), 32'(e_rdy[k]));
            chk("cur_sel", k, 32'(cs_w[k]), 32'(m_sel[k][AW-1:0]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        ui_pad     = 8'($urandom);
        uio_pad_in = 8'($urandom);
        ext_rst_n  = ($urandom_range(0, 9) != 0);
    endtask

    task automatic shuffle_ow();
        for (int s = 0; s < NS; s++) ow_all[s*24 +: 24] = 24'($urandom);
    endtask

    // Hold the request on each instance until that instance accepts it.
    task automatic do_req(input int unsigned addr);
        int unsigned n;
        sel_addr = AW'(addr);
        sv = 2'b11;
        n = 0;
        while (sv != 2'b00 && n < 400) begin
            step();
            for (int k = 0; k < 2; k++) if (m_acc[k]) sv[k] = 1'b0;
            n++;
        end
        chk("req_timeout", 0, 32'(sv), 32'(0));
        sv = 2'b00;
    endtask

    task automatic wait_state(input mst_t s);
        int unsigned n;
        n = 0;
        while (!(m_st[0] == s && m_st[1] == s) && n < 400) begin
            step();
            n++;
        end
        chk("wait_timeout", 0, 32'(n < 400), 32'(1));
    endtask

    initial begin
        model_reset();
        shuffle_ow();
        // reset values
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (3) step();

        // OFF -> slot 3, then directed ow mux check
        do_req(3);
        wait_state(M_RUN);
        repeat (10) step();
        ow_all[3*24 +: 24] = 24'hA55A3C;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("uo_direct", k, 32'(uo_w[k]), 32'h3C);
            chk("uio_out_direct", k, 32'(uioo_w[k]), 32'h5A);
            chk("uio_oe_direct", k, 32'(oe_w[k]), 32'hA5);
            chk("ena_direct", k, ena_w[k], 32'h8);
        end

        // RUN slot 3 -> slot 5
        step();
        do_req(5);
        wait_state(M_RUN);
        repeat (5) step();

        // all-off request
        do_req(40);
        wait_state(M_OFF);
        repeat (4) step();

        // request held during RESET is ignored until RUN
        do_req(3);
        repeat (3) step();
        do_req(7);
        wait_state(M_RUN);
        step();

        // async reset in the middle of RESET
        do_req(9);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        // same-slot switch still runs the full sequence
        do_req(5);
        wait_state(M_RUN);
        do_req(5);
        wait_state(M_RUN);

        // random traffic
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) shuffle_ow();
            do_req($urandom_range(0, 40));
            repeat ($urandom_range(0, 20)) step();
        end
        wait_state(M_RUN);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
